axi_sram_slave: RTL and testbench

AXI3 responder that terminates the AXI port of the CPU bridge on a synchronous single-port SRAM. It serves the instruction and data traffic that the bridge emits (IDs 0/1, INCR/FIXED bursts, 32-bit data). It is the memory-side counterpart used in the SoC and simulation top. One transaction is in flight at a time, at full throughput of one beat per cycle in both directions.

---
 rtl/axi_pkg.sv | 18 +
 rtl/axi_burst_addr.sv | 31 +++
 rtl/axi_sram_slave.sv | 196 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 definitions for the CPU bridge and its memory-side responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_WRESP
    } sram_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for an AXI burst; WRAP and reserved encodings step like
// INCR but are flagged so the responder can answer them with SLVERR.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        bad_burst
);

    logic [31:0] incr_addr;

    assign incr_addr = addr + (32'd1 << size);

    always_comb begin
        next_addr = incr_addr;
        bad_burst = 1'b1;
        case (burst)
            BURST_FIXED: begin
                next_addr = addr;
                bad_burst = 1'b0;
            end
            BURST_INCR: bad_burst = 1'b0;
            BURST_WRAP: bad_burst = 1'b1;
            default:    bad_burst = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder on a 1-cycle-latency single-port SRAM; one transaction in
// flight, one beat per cycle, round-robin between AR and AW on contention.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    sram_state_e     state, state_nxt;
    logic            prio_read;
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [7:0]      len, beat;
    logic [2:0]      size;
    logic [1:0]      burst, bresp_q;
    logic [31:0]     next_addr;
    logic            bad_burst, last_beat, w_end;
    logic            unused_ok;

    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    axi_burst_addr u_burst_addr (
        .addr      (addr),
        .size      (size),
        .burst     (burst),
        .next_addr (next_addr),
        .bad_burst (bad_burst)
    );

    assign last_beat = (beat == len);
    assign w_end     = wlast | last_beat;

    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        awready   = 1'b0;
        sram_en   = 1'b0;
        sram_we   = 4'b0000;
        sram_addr = addr[ADDR_W+1:2];
        case (state)
            ST_IDLE: begin
                arready = arvalid & (~awvalid | prio_read);
                awready = awvalid & (~arvalid | ~prio_read);
                if (arready) begin
                    sram_en   = 1'b1;
                    sram_addr = araddr[ADDR_W+1:2];
                    state_nxt = ST_READ;
                end else if (awready) begin
                    state_nxt = ST_WRITE;
                end
            end
            // Prefetch the next word on the handshake so rdata is ready next cycle
            ST_READ: begin
                if (rready) begin
                    if (last_beat) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        sram_en   = 1'b1;
                        sram_addr = next_addr[ADDR_W+1:2];
                    end
                end
            end
            ST_WRITE: begin
                if (wvalid) begin
                    sram_en = 1'b1;
                    sram_we = wstrb;
                    if (w_end) state_nxt = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (bready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign rvalid     = (state == ST_READ);
    assign wready     = (state == ST_WRITE);
    assign bvalid     = (state == ST_WRESP);
    assign rlast      = rvalid & last_beat;
    assign rdata      = sram_rdata;
    assign rid        = id;
    assign bid        = id;
    assign rresp      = bad_burst ? RESP_SLVERR : RESP_OKAY;
    assign bresp      = bresp_q;
    assign sram_wdata = wdata;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= ST_IDLE;
            prio_read <= 1'b1;
            id        <= '0;
            burst     <= BURST_FIXED;
            beat      <= 8'd0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && arvalid && awvalid) prio_read <= ~prio_read;
            case (state)
                ST_IDLE: begin
                    if (arready) begin
                        id    <= arid;
                        burst <= arburst;
                        beat  <= 8'd0;
                    end else if (awready) begin
                        id    <= awid;
                        burst <= awburst;
                        beat  <= 8'd0;
                    end
                end
                ST_READ: begin
                    if (rready && !last_beat) beat <= beat + 8'd1;
                end
                // A burst is only OKAY when wlast lands exactly on the final beat
                ST_WRITE: begin
                    if (wvalid) begin
                        if (w_end)
                            bresp_q <= (wlast && last_beat && !bad_burst) ? RESP_OKAY : RESP_SLVERR;
                        else
                            beat <= beat + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        case (state)
            ST_IDLE: begin
                if (arready) begin
                    addr <= araddr;
                    len  <= arlen;
                    size <= arsize;
                end else if (awready) begin
                    addr <= awaddr;
                    len  <= awlen;
                    size <= awsize;
                end
            end
            ST_READ: begin
                if (rready && !last_beat) addr <= next_addr;
            end
            ST_WRITE: begin
                if (wvalid && !w_end) addr <= next_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a word-array memory model.
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int ADDR_W = 8;
    localparam int ID_W   = 4;
    localparam int WORDS  = 1 << ADDR_W;

    logic              aclk, areset;
    logic [ID_W-1:0]   arid, awid, wid, rid, bid;
    logic [31:0]       araddr, awaddr, rdata, wdata, sram_wdata, sram_rdata;
    logic [7:0]        arlen, awlen;
    logic [2:0]        arsize, awsize, arprot, awprot;
    logic [1:0]        arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]        arcache, awcache, wstrb, sram_we;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready;
    logic              bvalid, bready, sram_en;
    logic [ADDR_W-1:0] sram_addr;

    logic [31:0] sram    [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic        preload;
    logic [3:0]  strb_q [$];

    int n_vec = 0;
    int n_err = 0;

    axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] seed_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h9E3779B9 * (i + 1);
    endfunction

    // Behavioural SRAM: byte-write, 1-cycle read latency, output held while idle
    always @(posedge aclk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= seed_word(i);
        end else if (sram_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            sram_rdata <= sram[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] size,
                                         input logic [1:0] burst);
        if (burst == 2'b00) return a;
        return a + (32'd1 << size);
    endfunction

    function automatic logic [1:0] burst_resp(input logic [1:0] burst);
        return (burst == 2'b00 || burst == 2'b01) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [ADDR_W-1:0] word_of(input logic [31:0] a);
        return a[ADDR_W+1:2];
    endfunction

    task automatic issue_ar(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        @(negedge aclk);
        check("ar_ready", arready, 1);
        check("ar_sram_en", sram_en, 1);
        check("ar_sram_addr", sram_addr, word_of(a));
        check("ar_sram_we", sram_we, 0);
        check("ar_rvalid_low", rvalid, 0);
        check("ar_bvalid_low", bvalid, 0);
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic read_beats(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int mode);
        logic [31:0] cur = a;
        logic [31:0] nxt;
        int beat = 0;
        int cyc = 0;
        while (beat <= int'(len) && cyc < 4 * int'(len) + 40) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = ((cyc % 2) == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge aclk);
            check("r_valid", rvalid, 1);
            check("r_data", rdata, ref_mem[word_of(cur)]);
            check("r_last", rlast, beat == int'(len));
            check("r_resp", rresp, burst_resp(burst));
            check("r_id", rid, id);
            if (!rready) begin
                check("r_hold_no_en", sram_en, 0);
            end else if (beat == int'(len)) begin
                check("r_last_no_en", sram_en, 0);
            end else begin
                nxt = step(cur, size, burst);
                check("r_next_en", sram_en, 1);
                check("r_next_addr", sram_addr, word_of(nxt));
            end
            @(posedge aclk); #1;
            if (rready) begin
                beat++;
                cur = step(cur, size, burst);
            end
            cyc++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) check("r_timeout", beat, int'(len) + 1);
    endtask

    task automatic issue_aw(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        @(negedge aclk);
        check("aw_ready", awready, 1);
        check("aw_no_en", sram_en, 0);
        check("aw_rvalid_low", rvalid, 0);
        check("aw_bvalid_low", bvalid, 0);
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    // early: -1 wlast on the final beat, -2 wlast never raised, k>=0 wlast on beat k
    task automatic write_beats(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int early);
        logic [31:0] cur = a;
        logic [1:0]  exp_resp = 2'b10;
        int beat = 0;
        int cyc = 0;
        int delay;
        bit done = 0;
        while (!done && cyc < 4 * int'(len) + 40) begin
            wvalid = ($urandom_range(0, 3) != 0);
            wdata  = $urandom;
            if (wvalid && strb_q.size() > 0) wstrb = strb_q.pop_front();
            else                             wstrb = 4'($urandom_range(0, 15));
            if (early == -1)     wlast = (beat == int'(len));
            else if (early >= 0) wlast = (beat == early);
            else                 wlast = 1'b0;
            @(negedge aclk);
            check("w_ready", wready, 1);
            if (wvalid) begin
                check("w_sram_en", sram_en, 1);
                check("w_sram_we", sram_we, wstrb);
                check("w_sram_addr", sram_addr, word_of(cur));
                check("w_sram_wdata", sram_wdata, wdata);
            end
            @(posedge aclk); #1;
            if (wvalid) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) ref_mem[word_of(cur)][8*b +: 8] = wdata[8*b +: 8];
                if (wlast || beat == int'(len)) begin
                    done = 1;
                    exp_resp = (wlast && beat == int'(len) && burst_resp(burst) == 2'b00) ? 2'b00 : 2'b10;
                end else begin
                    beat++;
                    cur = step(cur, size, burst);
                end
            end
            cyc++;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (!done) check("w_timeout", 0, 1);
        delay = $urandom_range(0, 2);
        for (int k = 0; k <= delay; k++) begin
            bready = (k == delay);
            @(negedge aclk);
            check("b_valid", bvalid, 1);
            check("b_id", bid, id);
            check("b_resp", bresp, exp_resp);
            check("b_wready_low", wready, 0);
            @(posedge aclk); #1;
        end
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        issue_ar(id, a, len, size, burst);
        read_beats(id, a, len, size, burst, mode);
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int early);
        issue_aw(id, a, len, size, burst);
        write_beats(id, a, len, size, burst, early);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [ID_W-1:0] id;
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int early, nbad;

        areset = 1'b1; preload = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        arlock = '0; arcache = '0; arprot = '0; awlock = '0; awcache = '0; awprot = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = seed_word(i);
        repeat (2) @(posedge aclk);
        #1 preload = 1'b0;

        @(negedge aclk);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_wready", wready, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_rid", rid, 0);
        check("rst_bid", bid, 0);
        check("rst_rresp", rresp, 0);
        check("rst_bresp", bresp, 0);
        check("rst_state", dut.state == ST_IDLE, 1);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;

        do_read(4'h3, 32'h10, 8'd0, 3'd2, BURST_INCR, 0);
        do_read(4'h1, 32'h100, 8'd3, 3'd2, BURST_INCR, 1);

        strb_q.push_back(4'hF);
        strb_q.push_back(4'h3);
        do_write(4'h5, 32'h20, 8'd1, 3'd2, BURST_INCR, -1);
        check("w_word8", sram[8], ref_mem[8]);
        check("w_word9", sram[9], ref_mem[9]);
        check("w_word9_hi", sram[9][31:16], seed_word(9) >> 16);
        strb_q.delete();

        // Contention: read wins first, then write, then read again
        for (int round = 0; round < 2; round++) begin
            arid = 4'h0; araddr = 32'h40 + 32'(round * 16); arlen = 8'd1; arsize = 3'd2;
            arburst = BURST_INCR; arvalid = 1'b1;
            awid = 4'h1; awaddr = 32'h80 + 32'(round * 16); awlen = 8'd1; awsize = 3'd2;
            awburst = BURST_INCR; awvalid = 1'b1;
            @(negedge aclk);
            check("prio_ar_first", arready, 1);
            check("prio_aw_wait", awready, 0);
            @(posedge aclk); #1;
            arvalid = 1'b0;
            read_beats(arid, araddr, arlen, arsize, arburst, 2);
            arvalid = 1'b1;
            @(negedge aclk);
            check("prio_aw_second", awready, 1);
            check("prio_ar_wait", arready, 0);
            @(posedge aclk); #1;
            awvalid = 1'b0;
            write_beats(awid, awaddr, awlen, awsize, awburst, -1);
            arvalid = 1'b0;
        end

        do_write(4'h7, 32'h200, 8'd3, 3'd2, BURST_INCR, 1);
        do_read(4'h2, 32'h300, 8'd3, 3'd2, BURST_WRAP, 0);
        do_read(4'h6, $urandom, 8'd255, 3'd2, BURST_INCR, 0);

        // Reset pulsed while beat 2 of an 8-beat read is on the bus
        issue_ar(4'h9, 32'h180, 8'd7, 3'd2, BURST_INCR);
        rready = 1'b1;
        repeat (2) @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_state", dut.state == ST_IDLE, 1);
        check("mid_rst_sram_en", sram_en, 0);
        rready = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_rvalid", rvalid, 0);
        check("post_rst_wready", wready, 0);
        @(posedge aclk); #1;
        do_read(4'hA, 32'h180, 8'd2, 3'd2, BURST_INCR, 2);

        for (int t = 0; t < 40; t++) begin
            id    = ID_W'($urandom);
            a     = $urandom;
            len   = 8'($urandom_range(0, 15));
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                do_read(id, a, len, size, burst, 2);
            end else begin
                case ($urandom_range(0, 5))
                    0:       early = -2;
                    1:       early = (len > 0) ? int'($urandom_range(0, int'(len) - 1)) : -1;
                    default: early = -1;
                endcase
                do_write(id, a, len, size, burst, early);
            end
        end

        nbad = 0;
        for (int i = 0; i < WORDS; i++) if (sram[i] !== ref_mem[i]) nbad++;
        check("mem_final", nbad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
